// File: rtl/tubo_carriles.sv
// Purpose: multi-lane falling-note engine; spawns notes, moves them on the frame tick,
//          judges pad strikes against a hit band, and renders per-pixel colour.
// Latency: spawn/hit/miss take effect one cycle after the request; pintar/pixel lag presentX/presentY by one cycle.
// Backpressure: spawn_ready drops when the addressed lane has no free slot or the lane index is out of range.
// Ports: clk/reset (sync, active-high), clear (flush notes, keep counters),
//        video_on/maquinaOut/presentX/presentY (VGA side), contar (frame tick),
//        spawn_valid/spawn_lane/spawn_ready (sequencer), hit_req (pads),
//        hit_pulse/miss_pulse/hit_count/miss_count (scoring), pintar/pixel (colour out).
module tubo_carriles #(
    parameter int          LANES       = 5,
    parameter int          SLOTS       = 4,
    parameter int          LANE_X0     = 80,
    parameter int          LANE_PITCH  = 96,
    parameter int          NOTE_W      = 64,
    parameter int          NOTE_H      = 64,
    parameter int          SPEED       = 1,
    parameter int          SCREEN_H    = 480,
    parameter int          HIT_Y       = 400,
    parameter int          HIT_WIN     = 16,
    parameter logic [23:0] LANE_COLORS = 24'o62541,
    parameter logic [2:0]  FONDO       = 3'd7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             video_on,
    input  logic             maquinaOut,
    input  logic [9:0]       presentX,
    input  logic [9:0]       presentY,
    input  logic             contar,
    input  logic             spawn_valid,
    input  logic [2:0]       spawn_lane,
    output logic             spawn_ready,
    input  logic [LANES-1:0] hit_req,
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count,
    output logic             pintar,
    output logic [2:0]       pixel
);

    // Hit band bounds; the lower bound clamps at zero for wide windows.
    localparam int BAND_LO = (HIT_Y > HIT_WIN) ? (HIT_Y - HIT_WIN) : 0;
    localparam int BAND_HI = HIT_Y + HIT_WIN;

    logic [SLOTS-1:0] act_q [LANES];
    logic [SLOTS-1:0] act_d [LANES];
    logic [9:0]       y_q   [LANES][SLOTS];
    logic [9:0]       y_d   [LANES][SLOTS];
    logic [LANES-1:0] hit_q, hit_d, miss_q, miss_d;
    logic [15:0]      hcnt_q, hcnt_d, mcnt_q, mcnt_d;
    logic             pin_q, pin_d;
    logic [2:0]       lane_q, lane_d;

    // Slot update: hits are judged on pre-tick y, the tick skips slots hit this
    // cycle (so hit beats retire), and spawns only consume slots that were
    // already free at the start of the cycle.
    always_comb begin
        logic        hfound;
        logic        sfound;
        logic        retire;
        logic [10:0] y11;
        logic [10:0] sum;
        logic [16:0] hsum;
        logic [16:0] msum;

        act_d       = act_q;
        y_d         = y_q;
        hit_d       = '0;
        miss_d      = '0;
        spawn_ready = 1'b0;
        hfound      = 1'b0;
        sfound      = 1'b0;
        retire      = 1'b0;
        y11         = '0;
        sum         = '0;

        for (int i = 0; i < LANES; i++) begin
            hfound = 1'b0;
            sfound = 1'b0;
            retire = 1'b0;
            if (spawn_lane == 3'(i)) begin
                spawn_ready = ~&act_q[i];
            end
            for (int s = 0; s < SLOTS; s++) begin
                y11 = {1'b0, y_q[i][s]};
                if (hit_req[i] && !hfound && act_q[i][s] &&
                    y11 >= 11'(BAND_LO) && y11 <= 11'(BAND_HI)) begin
                    hfound      = 1'b1;
                    act_d[i][s] = 1'b0;
                end
            end
            for (int s = 0; s < SLOTS; s++) begin
                sum = {1'b0, y_q[i][s]} + 11'(SPEED);
                if (contar && act_q[i][s] && act_d[i][s]) begin
                    if (sum >= 11'(SCREEN_H)) begin
                        act_d[i][s] = 1'b0;
                        retire      = 1'b1;
                    end else begin
                        y_d[i][s] = sum[9:0];
                    end
                end
            end
            for (int s = 0; s < SLOTS; s++) begin
                if (spawn_valid && spawn_lane == 3'(i) && !sfound && !act_q[i][s]) begin
                    sfound      = 1'b1;
                    act_d[i][s] = 1'b1;
                    y_d[i][s]   = '0;
                end
            end
            hit_d[i]  = hfound;
            miss_d[i] = retire | (hit_req[i] & ~hfound);
        end

        hsum   = {1'b0, hcnt_q} + 17'($countones(hit_d));
        msum   = {1'b0, mcnt_q} + 17'($countones(miss_d));
        hcnt_d = hsum[16] ? 16'hFFFF : hsum[15:0];
        mcnt_d = msum[16] ? 16'hFFFF : msum[15:0];
    end

    // Pixel hit test: strict on the left/top edge, inclusive on the right/bottom.
    always_comb begin
        logic [10:0] xl;
        logic [10:0] yt;
        pin_d  = 1'b0;
        lane_d = '0;
        xl     = '0;
        yt     = '0;
        for (int i = 0; i < LANES; i++) begin
            xl = 11'(LANE_X0 + i * LANE_PITCH);
            for (int s = 0; s < SLOTS; s++) begin
                yt = {1'b0, y_q[i][s]};
                if (!pin_d && act_q[i][s] &&
                    {1'b0, presentX} > xl && {1'b0, presentX} <= xl + 11'(NOTE_W) &&
                    {1'b0, presentY} > yt && {1'b0, presentY} <= yt + 11'(NOTE_H)) begin
                    pin_d  = 1'b1;
                    lane_d = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < LANES; i++) begin
                act_q[i] <= '0;
                for (int s = 0; s < SLOTS; s++) begin
                    y_q[i][s] <= '0;
                end
            end
            hit_q  <= '0;
            miss_q <= '0;
            pin_q  <= 1'b0;
            lane_q <= '0;
            if (reset) begin
                hcnt_q <= '0;
                mcnt_q <= '0;
            end
        end else begin
            act_q  <= act_d;
            y_q    <= y_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            hcnt_q <= hcnt_d;
            mcnt_q <= mcnt_d;
            pin_q  <= pin_d;
            lane_q <= lane_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign hit_count  = hcnt_q;
    assign miss_count = mcnt_q;
    assign pintar     = pin_q;
    assign pixel      = (video_on && maquinaOut && pin_q) ?
                        LANE_COLORS[5'(lane_q) * 5'd3 +: 3] : FONDO;

endmodule
